serial_tx_shifter: RTL and testbench
====================================

// Module: serial_tx_shifter
// PURPOSE
//  Parallel-to-serial transmitter: the driving end of the 1-bit d/q serial register path.
//  Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clk on d_out.
//  d_valid qualifies each emitted bit; done marks the last bit of a word.
//  Supports gapless back-to-back words; sits in front of the serial capture register.
// PARAMETERS
//  WIDTH      8   word length in bits; legal range 2..32
//  MSB_FIRST  1   1: bit WIDTH-1 sent first; 0: bit 0 sent first
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  load_valid in   1      load_data is valid this cycle
//  load_ready out  1      shifter can accept a word this cycle
//  load_data  in   WIDTH  parallel word to transmit
//  d_out      out  1      serial bit to the capture register
//  d_valid    out  1      d_out carries a payload bit this cycle
//  done       out  1      high with the last bit of each word
// BEHAVIOUR
//  Reset (reset==0, asynchronous): state=IDLE, shift reg=0, count=0.
//   Outputs during/after reset: load_ready=1, d_out=0, d_valid=0, done=0.
//  FSM states: IDLE, SHIFT.
//  IDLE: load_ready=1, d_valid=0, d_out=0.
//   On load_valid&&load_ready: capture load_data, count=0, go to SHIFT.
//  SHIFT: d_valid=1. d_out = current head bit (MSB or LSB per MSB_FIRST).
//   Each clk: shift by one, count+1.
//  Latency: first bit appears on d_out in the cycle after the accepting edge.
//   Exactly WIDTH consecutive d_valid cycles per word.
//  done=1 only in the SHIFT cycle where count==WIDTH-1, i.e. the last bit.
//  load_ready = IDLE || (SHIFT && count==WIDTH-1); combinational from state/count only.
//   It must not depend on load_valid.
//  Back-to-back: a handshake during the last-bit cycle reloads and stays in SHIFT.
//   The next word's first bit follows immediately; d_valid stays continuously high.
//  Last bit with no new handshake: return to IDLE; d_valid=0 and d_out=0 next cycle.
//  load_valid while load_ready=0: ignored. Upstream holds load_data stable until accepted.
//  Counter: $clog2(WIDTH) bits, wraps to 0 on reload; never counts past WIDTH-1.
//  Reset mid-word: word aborted immediately; no done pulse; outputs forced to reset values.
//  Shift fill bit is 0; d_out in IDLE is always 0.
// STRUCTURE
//  Package serial_pkg: typedef enum logic {IDLE, SHIFT} tx_state_e;
//   also localparam defaults SER_WIDTH=8 and SER_MSB_FIRST=1, shared with the capture side.
//  Single module. Counter and shift register are inline.
//  No sub-module is warranted beyond an optional bit_counter (count + last-bit flag).
// TESTING
//  Reset: reset=0 for 2 cycles -> load_ready=1, d_valid=0, d_out=0, done=0.
//  Single word: WIDTH=8, MSB_FIRST=1, load 8'hA5 -> d_out 1,0,1,0,0,1,0,1 on 8 d_valid cycles.
//   done is high on the 8th bit only, then IDLE.
//  LSB-first: MSB_FIRST=0, load 8'h01 -> d_out 1 then 0 x7.
//  Back-to-back: hold load_valid with 8'hFF then 8'h00 -> 16 continuous d_valid cycles.
//   d_out shows 8 ones then 8 zeros; done pulses at cycles 8 and 16; no idle gap.
//  Busy ignore: assert load_valid with 8'h3C mid-word (cycle 3) and drop it before the last bit.
//   -> original word sent intact; 8'h3C is never transmitted.
//  Reset mid-word: reset low after 4 bits of 8'hF0 -> d_valid=0 immediately, no done.
//   load_ready=1; a fresh load of 8'h81 after release transmits correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Types and defaults shared by the serial transmit shifter and the capture register.
package serial_pkg;

  typedef enum logic {IDLE, SHIFT} tx_state_e;

  localparam int SER_WIDTH     = 8;
  localparam bit SER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial transmitter: takes a word over valid/ready and emits it one bit per clk.
//
//   state | meaning
//   IDLE  | no word in flight, load_ready=1, d_out/d_valid held low
//   SHIFT | emitting the head bit; last bit when count==WIDTH-1
module serial_tx_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH,
  parameter bit MSB_FIRST = SER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             d_out,
  output logic             d_valid,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  tx_state_e        r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;

  logic w_shifting;
  logic w_last;
  logic w_accept;
  logic w_head;

  assign w_shifting = (r_state == SHIFT);
  assign w_last     = w_shifting && (r_count == LAST);
  assign w_accept   = load_valid && load_ready;
  assign w_head     = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

  // Ready comes from state/count only so upstream never sees a valid->ready loop.
  assign load_ready = !w_shifting || w_last;
  assign d_valid    = w_shifting;
  assign d_out      = w_shifting && w_head;
  assign done       = w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shift <= load_data;
      r_count <= '0;
    end else if (w_last) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else if (w_shifting) begin
      r_count <= r_count + 1'b1;
      if (MSB_FIRST) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      else           r_shift <= {1'b0, r_shift[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed bench: MSB-first and LSB-first instances checked bit by bit with immediate assertions.
module tb_serial_tx_shifter;

  logic       clk;
  logic       reset;
  logic       a_load_valid, b_load_valid;
  logic [7:0] a_load_data,  b_load_data;
  logic       a_load_ready, b_load_ready;
  logic       a_d_out,   b_d_out;
  logic       a_d_valid, b_d_valid;
  logic       a_done,    b_done;

  int total = 0;
  int bad   = 0;

  serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset),
    .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
    .d_out(a_d_out), .d_valid(a_d_valid), .done(a_done)
  );

  serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset),
    .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
    .d_out(b_d_out), .d_valid(b_d_valid), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // seq[7] is the first bit expected on the wire, seq[0] the last.
  task automatic expect_word_a(input string name, input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_valid%0d", name, i), a_d_valid, 1'b1);
      check($sformatf("%s_bit%0d", name, i), a_d_out, seq[7-i]);
      check($sformatf("%s_done%0d", name, i), a_done, (i == 7));
      check($sformatf("%s_ready%0d", name, i), a_load_ready, (i == 7));
      tick();
    end
  endtask

  task automatic expect_idle_a(input string name);
    check({name, "_idle_valid"}, a_d_valid, 1'b0);
    check({name, "_idle_dout"}, a_d_out, 1'b0);
    check({name, "_idle_done"}, a_done, 1'b0);
    check({name, "_idle_ready"}, a_load_ready, 1'b1);
  endtask

  initial begin
    reset        = 1'b0;
    a_load_valid = 1'b0;
    b_load_valid = 1'b0;
    a_load_data  = 8'h00;
    b_load_data  = 8'h00;
    tick();
    tick();
    check("rst_ready", a_load_ready, 1'b1);
    check("rst_valid", a_d_valid, 1'b0);
    check("rst_dout", a_d_out, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_ready_lsb", b_load_ready, 1'b1);
    check("rst_valid_lsb", b_d_valid, 1'b0);
    reset = 1'b1;
    tick();

    // Single word A5, MSB first: 1,0,1,0,0,1,0,1
    a_load_valid = 1'b1;
    a_load_data  = 8'hA5;
    tick();
    a_load_valid = 1'b0;
    expect_word_a("a5", 8'b1010_0101);
    expect_idle_a("a5");

    // LSB first, 01: 1 then seven 0s
    b_load_valid = 1'b1;
    b_load_data  = 8'h01;
    tick();
    b_load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb_valid%0d", i), b_d_valid, 1'b1);
      check($sformatf("lsb_bit%0d", i), b_d_out, (i == 0));
      check($sformatf("lsb_done%0d", i), b_done, (i == 7));
      tick();
    end
    check("lsb_idle_valid", b_d_valid, 1'b0);
    check("lsb_idle_dout", b_d_out, 1'b0);

    // Back-to-back FF then 00 with load_valid held: 16 gapless bits
    a_load_valid = 1'b1;
    a_load_data  = 8'hFF;
    tick();
    a_load_data  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) a_load_valid = 1'b0;
      check($sformatf("b2b_valid%0d", i), a_d_valid, 1'b1);
      check($sformatf("b2b_bit%0d", i), a_d_out, (i < 8));
      check($sformatf("b2b_done%0d", i), a_done, (i == 7 || i == 15));
      check($sformatf("b2b_ready%0d", i), a_load_ready, (i == 7 || i == 15));
      tick();
    end
    expect_idle_a("b2b");

    // Busy ignore: C3 in flight, 3C offered from bit 3 to bit 5 must not be taken
    a_load_valid = 1'b1;
    a_load_data  = 8'hC3;
    tick();
    a_load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] seq;
      seq = 8'b1100_0011;
      check($sformatf("busy_bit%0d", i), a_d_out, seq[7-i]);
      check($sformatf("busy_done%0d", i), a_done, (i == 7));
      if (i == 2) begin
        a_load_valid = 1'b1;
        a_load_data  = 8'h3C;
      end
      if (i == 5) a_load_valid = 1'b0;
      tick();
    end
    expect_idle_a("busy");

    // Reset mid-word: four bits of F0, then asynchronous reset
    a_load_valid = 1'b1;
    a_load_data  = 8'hF0;
    tick();
    a_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_bit%0d", i), a_d_out, 1'b1);
      tick();
    end
    reset = 1'b0;
    #1;
    check("abort_valid", a_d_valid, 1'b0);
    check("abort_dout", a_d_out, 1'b0);
    check("abort_done", a_done, 1'b0);
    check("abort_ready", a_load_ready, 1'b1);
    tick();
    check("abort_hold_valid", a_d_valid, 1'b0);
    reset = 1'b1;
    tick();
    expect_idle_a("post_rst");

    a_load_valid = 1'b1;
    a_load_data  = 8'h81;
    tick();
    a_load_valid = 1'b0;
    expect_word_a("x81", 8'b1000_0001);
    expect_idle_a("x81");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
